// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, one or two stop bits, valid/ready word intake.
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  bit_end;

    assign tx_ready = (state_q == S_IDLE) && !reset;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        txd_d   = txd_q;

        accept  = tx_valid && tx_ready;
        bit_end = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    txd_d   = 1'b0;
                    shreg_d = tx_data;
                    par_d   = (PARITY == 2) ? (^tx_data) : (~^tx_data);
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        // Flag the final cycle of the last stop bit so it lines up with the last busy cycle
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four configurations, a line-decoding
// monitor that compares each received frame against hand-written bit patterns.
module tb_uart_tx_cfg;

    localparam int CPB = 4;
    localparam int NI  = 4;
    localparam int DB [NI] = '{8, 8, 8, 7};
    localparam int PB [NI] = '{0, 2, 1, 0};
    localparam int SB [NI] = '{1, 1, 1, 2};

    typedef struct {
        logic [12:0] bits;
        int          nb;
        int          gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst        [NI];
    logic       tx_valid   [NI];
    logic [8:0] tx_data    [NI];
    logic       tx_ready_w [NI];
    logic       txd_w      [NI];
    logic       busy_w     [NI];
    logic       done_w     [NI];

    int   sel = 0;
    exp_t exp_q [$];
    int   n_chk = 0;
    int   n_err = 0;
    int   idle_cnt = 0;
    bit   in_frame = 1'b0;

    logic txd_s, rdy_s, busy_s, done_s, rst_s;

    always #5 clk = ~clk;

    always_comb begin
        txd_s  = txd_w[sel];
        rdy_s  = tx_ready_w[sel];
        busy_s = busy_w[sel];
        done_s = done_w[sel];
        rst_s  = rst[sel];
    end

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(rst[0]), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(rst[1]), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(rst[2]), .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(rst[3]), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready_w[3]), .txd(txd_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d): got %0h, expected %0h", name, sel, act, exp);
        end
    endtask

    // Build an expected frame from a string of line levels in transmit order
    function automatic exp_t mk(input string s, input int gap);
        exp_t e;
        e.bits = '0;
        for (int i = 0; i < s.len(); i++) begin
            e.bits[i] = (s[i] == 8'h31);
        end
        e.nb  = s.len();
        e.gap = gap;
        return e;
    endfunction

    task automatic decode_one();
        int          g       = sel;
        int          nb      = 1 + DB[g] + ((PB[g] != 0) ? 1 : 0) + SB[g];
        logic [12:0] bits    = '0;
        int          dones   = 0;
        int          done_at = -1;
        bit          busy_ok = 1'b1;
        bit          aborted = 1'b0;
        int          gap     = idle_cnt;
        exp_t        e;
        in_frame = 1'b1;
        for (int c = 0; c < nb * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (rst_s === 1'b1) begin
                aborted = 1'b1;
                break;
            end
            if (c % CPB == CPB / 2) bits[c / CPB] = txd_s;
            if (done_s === 1'b1) begin
                dones++;
                done_at = c;
            end
            if (busy_s !== 1'b1) busy_ok = 1'b0;
        end
        if (aborted) begin
            check("no_done_before_reset", 32'(dones), 32'd0);
            idle_cnt = 0;
            in_frame = 1'b0;
            return;
        end
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_frame (dut %0d): got bits %0h, expected no frame", g, bits);
        end else begin
            e = exp_q.pop_front();
            check("frame_bits", 32'(bits), 32'(e.bits));
            check("tx_done_count", 32'(dones), 32'd1);
            check("frame_length", 32'(done_at + 1), 32'(e.nb * CPB));
            check("busy_in_frame", 32'(busy_ok), 32'd1);
            if (e.gap >= 0) check("idle_gap", 32'(gap), 32'(e.gap));
        end
        @(negedge clk);
        check("ready_after_done", 32'(rdy_s), 32'd1);
        check("idle_busy", 32'(busy_s), 32'd0);
        check("idle_txd", 32'(txd_s), 32'd1);
        idle_cnt = 1;
        in_frame = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (txd_s === 1'b0 && rst_s === 1'b0) decode_one();
            else idle_cnt++;
        end
    end

    task automatic send(input logic [8:0] d, input bit hold);
        int t = 0;
        tx_data[sel]  = d;
        tx_valid[sel] = 1'b1;
        while (rdy_s !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                n_chk++;
                n_err++;
                $display("FAIL handshake_timeout (dut %0d): got tx_ready low, expected high", sel);
                tx_valid[sel] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        check("txd_low_after_accept", 32'(txd_s), 32'd0);
        if (!hold) tx_valid[sel] = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || in_frame) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_timeout (dut %0d): got %0d pending frames, expected 0", sel, exp_q.size());
        end
    endtask

    initial begin : stimulus
        for (int g = 0; g < NI; g++) begin
            rst[g]      = 1'b1;
            tx_valid[g] = 1'b0;
            tx_data[g]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            sel = g;
            #1;
            check("reset_txd", 32'(txd_s), 32'd1);
            check("reset_busy", 32'(busy_s), 32'd0);
            check("reset_done", 32'(done_s), 32'd0);
            check("reset_ready", 32'(rdy_s), 32'd0);
        end
        for (int g = 0; g < NI; g++) rst[g] = 1'b0;
        for (int g = 0; g < NI; g++) begin
            sel = g;
            #1;
            check("ready_after_release", 32'(rdy_s), 32'd1);
        end
        @(negedge clk);

        // 8N1, 0xA5
        sel = 0;
        exp_q.push_back(mk("0101001011", -1));
        send(9'h0A5, 1'b0);
        wait_idle();

        // even parity, 0x07 -> parity bit 1
        sel = 1;
        exp_q.push_back(mk("01110000011", -1));
        send(9'h007, 1'b0);
        wait_idle();

        // odd parity, 0x07 -> parity bit 0
        sel = 2;
        exp_q.push_back(mk("01110000001", -1));
        send(9'h007, 1'b0);
        wait_idle();

        // 7 data bits, 2 stop bits, 0x55
        sel = 3;
        exp_q.push_back(mk("0101010111", -1));
        send(9'h055, 1'b0);
        wait_idle();

        // back-to-back with tx_valid held: one idle cycle between frames
        sel = 0;
        exp_q.push_back(mk("0001111001", -1));
        exp_q.push_back(mk("0110000111", 1));
        send(9'h03C, 1'b1);
        send(9'h0C3, 1'b0);
        wait_idle();

        // reset in the middle of the data bits of 0xFF
        send(9'h0FF, 1'b0);
        repeat (10) @(negedge clk);
        rst[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_txd", 32'(txd_s), 32'd1);
            check("rst_mid_ready", 32'(rdy_s), 32'd0);
            check("rst_mid_done", 32'(done_s), 32'd0);
        end
        rst[0] = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk("0010010001", -1));
        send(9'h012, 1'b0);
        wait_idle();

        // data change and extra valid while busy must be ignored
        exp_q.push_back(mk("0010110101", -1));
        send(9'h05A, 1'b0);
        repeat (8) @(negedge clk);
        tx_data[0]  = 9'h0FF;
        tx_valid[0] = 1'b1;
        #1;
        check("ready_while_busy", 32'(rdy_s), 32'd0);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        wait_idle();
        repeat (50) @(negedge clk);
        check("no_extra_frame", 32'(busy_s), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
